audio_sfx_gen: RTL and testbench
================================

AUDIO_SFX_GEN -- requirements
Module: audio_sfx_gen

Interface
REQ-001 clk_25mhz  in  1  system clock, 25 MHz pixel clock shared with the processor and VGA stages.
REQ-002 rst  in  1  reset, synchronous, active-low; sampled on the rising edge of clk_25mhz.
REQ-003 audio_en  in  1  start strobe from the processor; one-cycle high requests a sound effect.
REQ-004 audio_sel  in  2  effect select, sampled when audio_en=1: 0 gunshot, 1 quack, 2 fall, 3 laugh.
REQ-005 audio_vol  in  4  volume, sampled when audio_en=1; 0 = silent, 15 = loudest.
REQ-006 audio_pwm  out  1  PWM audio output to the external filter/amplifier.
REQ-007 audio_busy  out  1  high while an effect is playing.
REQ-008 audio_done  out  1  one-cycle pulse when an effect completes naturally.

Function
REQ-009 Effect table (half-period in clocks / duration in ms / sweep per ms):
- sel0: 2500 / 50 / +250
- sel1: 12500 / 200 / 0
- sel2: 6250 / 500 / +50
- sel3: 25000 / 300 / 0
REQ-010 The FSM SHALL have states IDLE, PLAY and DONE; DONE SHALL last exactly one cycle and then return to IDLE.
REQ-011 IDLE with audio_en=1 SHALL go to PLAY on the next edge.
- That edge latches sel, vol, table half-period and duration.
- It clears the tone counter, ms prescaler and tone level (0).
REQ-012 audio_en=1 in PLAY or DONE SHALL restart the effect with the new sel/vol (retrigger; newest wins).
- It re-enters PLAY with all counters reloaded.
- No audio_done pulse is issued for the aborted effect.
REQ-013 In PLAY the tone counter SHALL count 0..half_period-1; on reaching half_period-1 it wraps to 0 and the tone level toggles.
REQ-014 In PLAY a ms prescaler SHALL count 0..24999; at 24999 it wraps and issues a ms tick.
REQ-015 Each ms tick SHALL:
- decrement the remaining duration;
- add the sweep value to half_period, 16-bit, saturating at 65535.
- The new half_period takes effect at the next tone-counter comparison.
REQ-016 The ms tick that brings remaining duration to 0 SHALL move PLAY to DONE; the effect therefore lasts exactly duration x 25000 cycles after entering PLAY.
REQ-017 A free-running 8-bit PWM counter SHALL run in all states.
- audio_pwm = 1 iff state=PLAY and tone level=1 and pwm_cnt < {vol,4'b0000}.
- vol=0 therefore produces constant 0 while audio_busy is still 1.
REQ-018 audio_busy SHALL be 1 exactly in PLAY.
REQ-019 audio_done SHALL be 1 exactly in DONE.
REQ-020 All outputs SHALL be registered; audio_busy rises on the edge after the accepted audio_en cycle (1-cycle latency).
REQ-021 audio_sel/audio_vol changes without audio_en SHALL have no effect on a playing effect.

Reset
REQ-022 rst=0 at a clock edge SHALL force:
- state IDLE;
- tone counter, prescaler, duration, half_period and pwm_cnt to 0;
- tone level 0;
- audio_pwm=0, audio_busy=0, audio_done=0.
REQ-023 Reset mid-PLAY SHALL abort silently: no audio_done pulse, output low on the next cycle.
REQ-024 audio_en asserted in the same cycle as rst=0 SHALL be ignored.

Verification
REQ-025 Single effect: audio_en=1, sel=1, vol=15 for one cycle.
- busy rises the next cycle and stays high for 5,000,000 cycles, then done pulses for one cycle.
- Tone toggles every 12500 cycles.
- audio_pwm duty while tone is high is 240/256.
REQ-026 Sweep: sel=0.
- First half-periods are 2500 cycles.
- After the first ms tick the half-period becomes 2750; after 49 ticks it is 14750.
- Effect ends after 1,250,000 cycles.
REQ-027 Retrigger: start sel=3, then at cycle 100,000 pulse audio_en with sel=1.
- No done pulse at the retrigger.
- busy stays high continuously; the new effect ends 5,000,000 cycles after the retrigger.
REQ-028 Silent: sel=2, vol=0.
- audio_pwm stays 0 for the whole effect.
- busy is high for 12,500,000 cycles; done pulses once.
REQ-029 Reset mid-play: rst=0 at cycle 1000 of sel=1.
- Next cycle busy=0, pwm=0, done=0.
- audio_en held together with rst=0 is ignored.
- A start after reset release behaves as in REQ-025.
REQ-030 Input isolation: toggle audio_sel/audio_vol during PLAY without audio_en -> waveform and duration unchanged.

Source files
------------

// File: rtl/audio_sfx_gen.sv
// rtl/audio_sfx_gen.sv - PWM sound-effect generator with tone sweep, duration timer and retrigger
module audio_sfx_gen #(
    parameter int MS_CYCLES = 25000
) (
    input  logic       clk_25mhz,
    input  logic       rst,
    input  logic       audio_en,
    input  logic [1:0] audio_sel,
    input  logic [3:0] audio_vol,
    output logic       audio_pwm,
    output logic       audio_busy,
    output logic       audio_done
);

    localparam logic [15:0] MS_LAST = 16'(MS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [3:0]  r_vol;
    logic [15:0] r_hp;
    logic [15:0] r_sweep;
    logic [15:0] r_dur;
    logic [15:0] r_tone_cnt;
    logic [15:0] r_presc;
    logic        r_level;
    logic [7:0]  r_pwm_cnt;
    logic        r_pwm;
    logic        r_busy;
    logic        r_done;

    logic [3:0]  w_vol_next;
    logic [15:0] w_hp_next;
    logic [15:0] w_sweep_next;
    logic [15:0] w_dur_next;
    logic [15:0] w_tone_cnt_next;
    logic [15:0] w_presc_next;
    logic        w_level_next;
    logic [7:0]  w_pwm_cnt_next;

    logic [15:0] w_tbl_hp;
    logic [15:0] w_tbl_dur;
    logic [15:0] w_tbl_sweep;
    logic [16:0] w_hp_sum;
    logic [15:0] w_hp_sat;
    logic        w_tick;
    logic        w_tone_last;

    // effect table lookup: starting half-period, duration in ms, half-period growth per ms
    always_comb begin
        w_tbl_hp    = 16'd2500;
        w_tbl_dur   = 16'd50;
        w_tbl_sweep = 16'd250;
        case (audio_sel)
            2'd0: begin w_tbl_hp = 16'd2500;  w_tbl_dur = 16'd50;  w_tbl_sweep = 16'd250; end
            2'd1: begin w_tbl_hp = 16'd12500; w_tbl_dur = 16'd200; w_tbl_sweep = 16'd0;   end
            2'd2: begin w_tbl_hp = 16'd6250;  w_tbl_dur = 16'd500; w_tbl_sweep = 16'd50;  end
            default: begin w_tbl_hp = 16'd25000; w_tbl_dur = 16'd300; w_tbl_sweep = 16'd0; end
        endcase
    end

    assign w_tick      = (r_state == S_PLAY) && (r_presc == MS_LAST);
    assign w_tone_last = (r_tone_cnt == r_hp - 16'd1);
    assign w_hp_sum    = {1'b0, r_hp} + {1'b0, r_sweep};
    assign w_hp_sat    = w_hp_sum[16] ? 16'hFFFF : w_hp_sum[15:0];

    // next-state logic: any accepted strobe (re)starts PLAY; last ms tick ends it
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (audio_en) w_state_next = S_PLAY;
            S_PLAY: begin
                if (audio_en)
                    w_state_next = S_PLAY;
                else if (w_tick && (r_dur == 16'd1))
                    w_state_next = S_DONE;
            end
            S_DONE: w_state_next = audio_en ? S_PLAY : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // datapath next values: reload on start, otherwise advance tone and ms timers while playing
    always_comb begin
        w_vol_next      = r_vol;
        w_hp_next       = r_hp;
        w_sweep_next    = r_sweep;
        w_dur_next      = r_dur;
        w_tone_cnt_next = r_tone_cnt;
        w_presc_next    = r_presc;
        w_level_next    = r_level;
        w_pwm_cnt_next  = r_pwm_cnt + 8'd1;
        if (audio_en) begin
            w_vol_next      = audio_vol;
            w_hp_next       = w_tbl_hp;
            w_sweep_next    = w_tbl_sweep;
            w_dur_next      = w_tbl_dur;
            w_tone_cnt_next = 16'd0;
            w_presc_next    = 16'd0;
            w_level_next    = 1'b0;
        end else if (r_state == S_PLAY) begin
            if (w_tone_last) begin
                w_tone_cnt_next = 16'd0;
                w_level_next    = ~r_level;
            end else begin
                w_tone_cnt_next = r_tone_cnt + 16'd1;
            end
            if (w_tick) begin
                w_presc_next = 16'd0;
                w_dur_next   = r_dur - 16'd1;
                w_hp_next    = w_hp_sat;
            end else begin
                w_presc_next = r_presc + 16'd1;
            end
        end
    end

    // state and datapath registers; outputs are registered from next values so they track the state with no extra lag
    always_ff @(posedge clk_25mhz) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_vol      <= 4'd0;
            r_hp       <= 16'd0;
            r_sweep    <= 16'd0;
            r_dur      <= 16'd0;
            r_tone_cnt <= 16'd0;
            r_presc    <= 16'd0;
            r_level    <= 1'b0;
            r_pwm_cnt  <= 8'd0;
            r_pwm      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_vol      <= w_vol_next;
            r_hp       <= w_hp_next;
            r_sweep    <= w_sweep_next;
            r_dur      <= w_dur_next;
            r_tone_cnt <= w_tone_cnt_next;
            r_presc    <= w_presc_next;
            r_level    <= w_level_next;
            r_pwm_cnt  <= w_pwm_cnt_next;
            r_pwm      <= (w_state_next == S_PLAY) && w_level_next &&
                          (w_pwm_cnt_next < {w_vol_next, 4'b0000});
            r_busy     <= (w_state_next == S_PLAY);
            r_done     <= (w_state_next == S_DONE);
        end
    end

    assign audio_pwm  = r_pwm;
    assign audio_busy = r_busy;
    assign audio_done = r_done;

endmodule

// File: tb/tb_audio_sfx_gen.sv
// tb/tb_audio_sfx_gen.sv - randomized and directed checks of audio_sfx_gen against a timeline model
module tb_audio_sfx_gen;

    localparam int MS_A = 25000;
    localparam int MS_B = 20;

    logic       clk;
    logic       rstn [2];
    logic       en   [2];
    logic [1:0] sel  [2];
    logic [3:0] vol  [2];
    logic       pwm  [2];
    logic       busy [2];
    logic       done [2];

    int n_checks = 0;
    int n_err    = 0;

    // model: mode 0 idle, 1 playing, 2 done pulse
    int mode [2];
    int e    [2];
    int seg  [2];
    int lvl  [2];
    int hp0  [2];
    int sw   [2];
    int dur  [2];
    int mvol [2];
    int pc   [2];
    int ms_of [2];
    int ndone [2];
    int nbusy [2];
    int npwm  [2];

    audio_sfx_gen #(.MS_CYCLES(MS_A)) u_a (
        .clk_25mhz (clk),
        .rst       (rstn[0]),
        .audio_en  (en[0]),
        .audio_sel (sel[0]),
        .audio_vol (vol[0]),
        .audio_pwm (pwm[0]),
        .audio_busy(busy[0]),
        .audio_done(done[0])
    );

    audio_sfx_gen #(.MS_CYCLES(MS_B)) u_b (
        .clk_25mhz (clk),
        .rst       (rstn[1]),
        .audio_en  (en[1]),
        .audio_sel (sel[1]),
        .audio_vol (vol[1]),
        .audio_pwm (pwm[1]),
        .audio_busy(busy[1]),
        .audio_done(done[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int tbl_hp(int s);
        case (s)
            0: return 2500;
            1: return 12500;
            2: return 6250;
            default: return 25000;
        endcase
    endfunction

    function automatic int tbl_dur(int s);
        case (s)
            0: return 50;
            1: return 200;
            2: return 500;
            default: return 300;
        endcase
    endfunction

    function automatic int tbl_sw(int s);
        case (s)
            0: return 250;
            2: return 50;
            default: return 0;
        endcase
    endfunction

    // half-period in force t cycles after the effect started
    function automatic int hpat(int i, int t);
        int x;
        x = hp0[i] + sw[i] * (t / ms_of[i]);
        return (x > 65535) ? 65535 : x;
    endfunction

    task automatic chk(string tag, int i, logic obs, logic ex);
        n_checks++;
        assert (obs === ex) else begin
            n_err++;
            $error("FAIL %s[%0d] observed=%0b expected=%0b", tag, i, obs, ex);
        end
    endtask

    task automatic chk_int(string tag, int obs, int ex);
        n_checks++;
        assert (obs === ex) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, ex);
        end
    endtask

    // one clock: model consumes the inputs seen at the edge, outputs compared on the falling edge
    task automatic step();
        logic c_r [2];
        logic c_e [2];
        int   c_s [2];
        int   c_v [2];
        for (int i = 0; i < 2; i++) begin
            c_r[i] = rstn[i]; c_e[i] = en[i]; c_s[i] = int'(sel[i]); c_v[i] = int'(vol[i]);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!c_r[i]) begin
                mode[i] = 0; pc[i] = 0; lvl[i] = 0;
            end else begin
                pc[i] = (pc[i] + 1) % 256;
                if (c_e[i]) begin
                    mode[i] = 1; e[i] = 0; seg[i] = 0; lvl[i] = 0;
                    hp0[i] = tbl_hp(c_s[i]); sw[i] = tbl_sw(c_s[i]);
                    dur[i] = tbl_dur(c_s[i]); mvol[i] = c_v[i];
                end else if (mode[i] == 1) begin
                    if (e[i] - seg[i] + 1 == hpat(i, e[i])) begin
                        lvl[i] = 1 - lvl[i];
                        seg[i] = e[i] + 1;
                    end
                    e[i]++;
                    if (e[i] == dur[i] * ms_of[i]) mode[i] = 2;
                end else if (mode[i] == 2) begin
                    mode[i] = 0;
                end
            end
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("busy", i, busy[i], mode[i] == 1);
            chk("done", i, done[i], mode[i] == 2);
            chk("pwm", i, pwm[i], (mode[i] == 1) && (lvl[i] == 1) && (pc[i] < mvol[i] * 16));
            ndone[i] += int'(done[i]);
            nbusy[i] += int'(busy[i]);
            npwm[i]  += int'(pwm[i]);
        end
    endtask

    // jit_a: scramble A's sel/vol without a strobe; mode_b: 0 quiet, 1 scramble only, 2 random strobes
    task automatic run(int n, bit jit_a, int mode_b);
        for (int k = 0; k < n; k++) begin
            if (jit_a) begin
                sel[0] = 2'($urandom); vol[0] = 4'($urandom);
            end
            en[1] = 1'b0;
            if (mode_b != 0) begin
                sel[1] = 2'($urandom); vol[1] = 4'($urandom);
                if (mode_b == 2 && $urandom_range(0, 399) == 0) en[1] = 1'b1;
            end
            step();
        end
        en[1] = 1'b0;
    endtask

    task automatic start(int i, int s, int v);
        sel[i] = 2'(s); vol[i] = 4'(v); en[i] = 1'b1;
        step();
        en[i] = 1'b0;
    endtask

    initial begin
        ms_of[0] = MS_A; ms_of[1] = MS_B;
        for (int i = 0; i < 2; i++) begin
            rstn[i] = 1'b0; en[i] = 1'b0; sel[i] = 2'd0; vol[i] = 4'd0;
            mode[i] = 0; e[i] = 0; seg[i] = 0; lvl[i] = 0; hp0[i] = 0; sw[i] = 0;
            dur[i] = 1; mvol[i] = 0; pc[i] = 0; ndone[i] = 0; nbusy[i] = 0; npwm[i] = 0;
        end
        step();
        en[0] = 1'b1; en[1] = 1'b1; sel[0] = 2'd1; sel[1] = 2'd1; vol[0] = 4'd15; vol[1] = 4'd15;
        step();
        en[0] = 1'b0; en[1] = 1'b0;
        step();
        rstn[0] = 1'b1; rstn[1] = 1'b1;
        step();

        // both instances start quack at full volume; A's inputs scrambled throughout
        sel[0] = 2'd1; vol[0] = 4'd15; en[0] = 1'b1;
        sel[1] = 2'd1; vol[1] = 4'd15; en[1] = 1'b1;
        step();
        en[0] = 1'b0; en[1] = 1'b0;
        run(4100, 1'b1, 0);
        chk_int("b_quack_done_count", ndone[1], 1);
        chk_int("b_quack_busy_cycles", nbusy[1], 200 * MS_B);

        start(1, 0, 7);
        run(1100, 1'b1, 0);
        chk_int("b_gunshot_done_count", ndone[1], 2);
        chk_int("b_gunshot_busy_cycles", nbusy[1], 250 * MS_B);

        npwm[1] = 0;
        start(1, 2, 0);
        run(10100, 1'b1, 0);
        chk_int("b_silent_done_count", ndone[1], 3);
        chk_int("b_silent_busy_cycles", nbusy[1], 750 * MS_B);
        chk_int("b_silent_pwm_high", npwm[1], 0);

        start(1, 3, 12);
        run(2000, 1'b1, 0);
        start(1, 1, 9);
        run(4100, 1'b1, 0);
        chk_int("b_retrig_done_count", ndone[1], 4);
        chk_int("b_retrig_busy_cycles", nbusy[1], 750 * MS_B + 2001 + 200 * MS_B);

        start(1, 0, 5);
        run(6000, 1'b1, 1);
        chk_int("b_isolate_done_count", ndone[1], 5);
        chk_int("a_quack_still_busy", int'(busy[0]), 1);
        chk_int("a_quack_no_done", ndone[0], 0);

        // reset mid-play with strobes held: both must go quiet and ignore the strobe
        rstn[0] = 1'b0; rstn[1] = 1'b0; en[0] = 1'b1; en[1] = 1'b1;
        step();
        chk_int("a_reset_busy", int'(busy[0]), 0);
        chk_int("b_reset_busy", int'(busy[1]), 0);
        en[0] = 1'b0; en[1] = 1'b0;
        step();
        rstn[0] = 1'b1; rstn[1] = 1'b1;
        step();
        chk_int("a_reset_no_done", ndone[0], 0);

        // A sweeps gunshot; B quack interrupted by reset at cycle 1000 then restarted
        sel[0] = 2'd0; vol[0] = 4'd10; en[0] = 1'b1;
        sel[1] = 2'd1; vol[1] = 4'd15; en[1] = 1'b1;
        step();
        en[0] = 1'b0; en[1] = 1'b0;
        run(999, 1'b1, 0);
        rstn[1] = 1'b0; en[1] = 1'b1;
        step();
        chk_int("b_midreset_busy", int'(busy[1]), 0);
        chk_int("b_midreset_pwm", int'(pwm[1]), 0);
        en[1] = 1'b0; rstn[1] = 1'b1;
        step();
        ndone[1] = 0; nbusy[1] = 0;
        start(1, 1, 15);
        run(4100, 1'b1, 0);
        chk_int("b_restart_done_count", ndone[1], 1);
        chk_int("b_restart_busy_cycles", nbusy[1], 200 * MS_B);
        run(25000, 1'b1, 2);
        chk_int("a_sweep_no_done", ndone[0], 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
